// File: rtl/regwrite_pkg.sv
// Shared definitions for the register-write decoder: default select width,
// zero-register index and the per-bit one-hot helper.
package regwrite_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 5;

    // Index of the hard-wired zero register for a given select width.
    function automatic int unsigned zero_index(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

    // One bit of a one-hot code: true when output position pos is selected.
    function automatic logic onehot_bit(input logic [31:0] sel, input int unsigned pos);
        return sel == 32'(pos);
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational index-to-one-hot stage with an enable; all-zero when disabled.
module onehot_decoder
    import regwrite_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   en,
    output logic [(1<<ADDR_W)-1:0] out
);

    localparam int unsigned N = 1 << ADDR_W;

    always_comb begin
        // NOTE: assign a default before any conditional logic so no path leaves
        // a bit unassigned; an unassigned path in always_comb infers a latch.
        out = '0;
        for (int i = 0; i < N; i++) begin
            out[i] = en && onehot_bit(32'(addr), i);
        end
    end

endmodule

// File: rtl/regwrite_decoder.sv
// Register-write decoder: registered one-hot write enable plus pending-write
// scoreboard. Define REGWRITE_DECODER_CHECK_EN to add the sticky err checker.
module regwrite_decoder
    import regwrite_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter bit          ZERO_EN = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   retire,
    input  logic [ADDR_W-1:0]      retire_addr,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [(1<<ADDR_W)-1:0] out,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic                   rd_busy
`ifdef REGWRITE_DECODER_CHECK_EN
    ,
    output logic                   err
`endif
);

    localparam int unsigned N        = 1 << ADDR_W;
    localparam int unsigned ZERO_IDX = zero_index(ADDR_W);

    logic         advance;
    logic         addr_suppressed;
    logic         issue_en;
    logic         retire_en;
    logic [N-1:0] issue_vec;
    logic [N-1:0] retire_vec;
    logic [N-1:0] busy_next;

    // Flush overrides stall, so the pipeline advances on either condition.
    assign advance         = !stall || flush;
    assign addr_suppressed = ZERO_EN && (32'(addr) == ZERO_IDX);
    assign issue_en        = write && !stall && !flush && !addr_suppressed;
    assign retire_en       = retire && advance;

    onehot_decoder #(.ADDR_W(ADDR_W)) u_issue_dec (
        .addr (addr),
        .en   (issue_en),
        .out  (issue_vec)
    );

    onehot_decoder #(.ADDR_W(ADDR_W)) u_retire_dec (
        .addr (retire_addr),
        .en   (retire_en),
        .out  (retire_vec)
    );

    // Set is applied after clear so a same-cycle re-issue keeps the entry busy.
    // The zero register is never issued, so its busy bit can never become set.
    assign busy_next = (busy & ~retire_vec) | issue_vec;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            out  <= '0;
            busy <= '0;
        end else if (advance) begin
            out  <= issue_vec;
            busy <= busy_next;
        end
    end

    // Hazard query sees the registered scoreboard only, no same-cycle bypass.
    assign rd_busy = busy[rd_addr];

`ifdef REGWRITE_DECODER_CHECK_EN
    logic out_bad;
    logic retire_bad;

    assign out_bad    = (out & (out - N'(1))) != '0;
    assign retire_bad = retire_en && !busy[retire_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (out_bad || retire_bad) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regwrite_decoder.sv
// Self-checking bench: two decoders (ZERO_EN=1 and ZERO_EN=0) share stimulus
// and are compared against an index/array level reference model.
module tb_regwrite_decoder;

    localparam int ADDR_W = 5;
    localparam int N      = 32;

    logic              clk = 1'b0;
    logic              reset, write, stall, flush, retire;
    logic [ADDR_W-1:0] addr, retire_addr, rd_addr;
    logic [N-1:0]      out_z, busy_z, out_n, busy_n;
    logic              rd_busy_z, rd_busy_n;
`ifdef REGWRITE_DECODER_CHECK_EN
    logic              err_z, err_n;
`endif

    always #5 clk = ~clk;

    regwrite_decoder #(.ADDR_W(ADDR_W), .ZERO_EN(1'b1)) dut_z (
        .clk(clk), .reset(reset), .write(write), .addr(addr), .stall(stall),
        .flush(flush), .retire(retire), .retire_addr(retire_addr), .rd_addr(rd_addr),
        .out(out_z), .busy(busy_z), .rd_busy(rd_busy_z)
`ifdef REGWRITE_DECODER_CHECK_EN
        , .err(err_z)
`endif
    );

    regwrite_decoder #(.ADDR_W(ADDR_W), .ZERO_EN(1'b0)) dut_n (
        .clk(clk), .reset(reset), .write(write), .addr(addr), .stall(stall),
        .flush(flush), .retire(retire), .retire_addr(retire_addr), .rd_addr(rd_addr),
        .out(out_n), .busy(busy_n), .rd_busy(rd_busy_n)
`ifdef REGWRITE_DECODER_CHECK_EN
        , .err(err_n)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 is the ZERO_EN=1 instance, index 1 ZERO_EN=0.
    bit m_busy [2][N];
    int m_out  [2];
    bit m_err  [2];

    task automatic check(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_busy(int z);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_busy[z][i];
        return v;
    endfunction

    function automatic logic [N-1:0] model_out(int z);
        logic [N-1:0] v;
        v = '0;
        if (m_out[z] >= 0) v[m_out[z]] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        int issue;
        for (int z = 0; z < 2; z++) begin
            if (reset) begin
                for (int i = 0; i < N; i++) m_busy[z][i] = 1'b0;
                m_out[z] = -1;
                m_err[z] = 1'b0;
            end else if (!stall || flush) begin
                issue = -1;
                if (write && !flush && !(z == 0 && int'(addr) == N - 1)) issue = int'(addr);
                if (retire) begin
                    if (!m_busy[z][retire_addr]) m_err[z] = 1'b1;
                    m_busy[z][retire_addr] = 1'b0;
                end
                if (issue >= 0) m_busy[z][issue] = 1'b1;
                m_out[z] = issue;
            end
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".out_z"},  out_z,  model_out(0));
        check({tag, ".busy_z"}, busy_z, model_busy(0));
        check({tag, ".out_n"},  out_n,  model_out(1));
        check({tag, ".busy_n"}, busy_n, model_busy(1));
        check1({tag, ".rd_busy_z"}, rd_busy_z, m_busy[0][rd_addr]);
        check1({tag, ".rd_busy_n"}, rd_busy_n, m_busy[1][rd_addr]);
`ifdef REGWRITE_DECODER_CHECK_EN
        check1({tag, ".err_z"}, err_z, m_err[0]);
        check1({tag, ".err_n"}, err_n, m_err[1]);
`endif
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(logic w, int a, logic s, logic f, logic r, int ra);
        write       = w;
        addr        = ADDR_W'(a);
        stall       = s;
        flush       = f;
        retire      = r;
        retire_addr = ADDR_W'(ra);
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0;
        drive(1, 3, 1, 0, 1, 3);
        m_out[0] = -1;
        m_out[1] = -1;
        @(negedge clk);

        // Reset with requests present: everything dropped.
        cycle("rst0");
        cycle("rst1");
        check("rst.out_z", out_z, 32'h0);
        check("rst.busy_z", busy_z, 32'h0);
        reset = 1'b0;

        // Single write to 3, then idle; busy[3] held until retired.
        drive(1, 3, 0, 0, 0, 0);
        rd_addr = 5'd3;
        cycle("s35.issue");
        check("s35.out", out_z, 32'h0000_0008);
        drive(0, 0, 0, 0, 0, 0);
        cycle("s35.idle0");
        check("s35.out_idle", out_z, 32'h0);
        check1("s35.busy3", busy_z[3], 1'b1);
        check1("s35.rd_busy", rd_busy_z, 1'b1);
        cycle("s35.idle1");
        drive(0, 0, 0, 0, 1, 3);
        cycle("s35.retire");
        check1("s35.busy3_clr", busy_z[3], 1'b0);
        drive(0, 0, 0, 0, 0, 0);

        // Write to the top index: suppressed with ZERO_EN=1, normal otherwise.
        drive(1, 31, 0, 0, 0, 0);
        rd_addr = 5'd31;
        cycle("s36.issue");
        check("s36.out_z", out_z, 32'h0);
        check("s36.busy_z", busy_z, 32'h0);
        check("s36.out_n", out_n, 32'h8000_0000);
        check1("s36.rd_busy_n", rd_busy_n, 1'b1);

        // Same-cycle issue and retire on a busy index: stays busy.
        drive(1, 7, 0, 0, 0, 0);
        cycle("s37.first");
        drive(1, 7, 0, 0, 1, 7);
        rd_addr = 5'd7;
        cycle("s37.collide");
        check1("s37.busy7", busy_z[7], 1'b1);
        check("s37.out", out_z, 32'h0000_0080);

        // Stall holds state; flush overrides stall.
        drive(1, 2, 0, 0, 0, 0);
        cycle("s38.pre");
        check("s38.pre_out", out_z, 32'h0000_0004);
        drive(1, 5, 1, 0, 1, 2);
        for (int i = 0; i < 3; i++) begin
            cycle("s38.stall");
            check("s38.stall_out", out_z, 32'h0000_0004);
            check("s38.stall_busy", busy_z, 32'h0000_0084);
        end
        drive(1, 5, 1, 1, 0, 0);
        cycle("s38.flush");
        check("s38.flush_out", out_z, 32'h0);
        check1("s38.flush_busy5", busy_z[5], 1'b0);

`ifdef REGWRITE_DECODER_CHECK_EN
        // Retire of a non-busy index: sticky err until reset.
        drive(0, 0, 0, 0, 1, 9);
        cycle("s40.retire");
        check1("s40.err", err_z, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        cycle("s40.hold0");
        cycle("s40.hold1");
        check1("s40.err_hold", err_z, 1'b1);
`endif

        // Reset mid-stream with busy = 0xF0.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cycle("s39.clean");
        reset = 1'b0;
        for (int a = 4; a < 8; a++) begin
            drive(1, a, 0, 0, 0, 0);
            cycle("s39.fill");
        end
        check("s39.busy_f0", busy_z, 32'h0000_00F0);
        reset = 1'b1;
        drive(1, 1, 1, 0, 1, 4);
        cycle("s39.reset");
        check("s39.out", out_z, 32'h0);
        check("s39.busy", busy_z, 32'h0);
`ifdef REGWRITE_DECODER_CHECK_EN
        check1("s39.err", err_z, 1'b0);
`endif
        reset = 1'b0;
        drive(1, 1, 0, 0, 0, 0);
        cycle("s39.resume");
        check("s39.resume_out", out_z, 32'h0000_0002);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, N - 1)),
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, N - 1)));
            if ($urandom_range(0, 3) == 0) retire_addr = addr;
            rd_addr = ADDR_W'($urandom_range(0, N - 1));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
